// File: rtl/dist_topk_select_if.sv
// dist_topk_select_if
//   Bundles the distance stream coming from distcalc_euclid and the sorted
//   top-K result going to the k-NN vote stage.
//
//   Handshake: DIST_VALID is a one-cycle strobe with no back-pressure (there is
//   no ready). A sample is taken on every rising clk edge where DIST_VALID=1;
//   dist_in and LAST are meaningful only on those edges. CLR is a synchronous
//   clear that overrides a coincident strobe.
//
//   master : the producer (drives CLR, DIST_VALID, dist_in, LAST)
//   slave  : dist_topk_select (drives the result list, DONE, OVF, fsm_state)
//   fsm_state is a debug view of the selector state (IDLE/FILL/FULL/DONE).
interface dist_topk_select_if #(
  parameter int VARWIDTH = 32,
  parameter int K        = 4,
  parameter int IDXWIDTH = 10
);
  localparam int CW = $clog2(K + 1);

  logic                    CLR;
  logic                    DIST_VALID;
  logic [VARWIDTH-1:0]     dist_in;
  logic                    LAST;
  logic [K*VARWIDTH-1:0]   topk_dist;
  logic [K*IDXWIDTH-1:0]   topk_idx;
  logic [CW-1:0]           topk_cnt;
  logic                    DONE;
  logic                    OVF;
  logic [1:0]              fsm_state;

  modport master (
    output CLR, DIST_VALID, dist_in, LAST,
    input  topk_dist, topk_idx, topk_cnt, DONE, OVF, fsm_state
  );

  modport slave (
    input  CLR, DIST_VALID, dist_in, LAST,
    output topk_dist, topk_idx, topk_cnt, DONE, OVF, fsm_state
  );
endinterface

// File: rtl/dist_topk_select.sv
// dist_topk_select
//   Keeps the K smallest distances of one query (one CLR..LAST sequence) and the
//   candidate indices that produced them, sorted ascending (slot 0 = smallest).
//   Each accepted sample is inserted in a single cycle; results are visible one
//   cycle after the strobing edge, and a strobe every cycle is sustained.
//
//   Ports:
//     clk    rising-edge clock
//     RST_N  asynchronous active-low reset
//     bus    dist_topk_select_if.slave
//              in : CLR, DIST_VALID, dist_in, LAST
//              out: topk_dist, topk_idx (slot j at [j*W +: W]), topk_cnt,
//                   DONE, OVF (sticky index exhaustion), fsm_state (debug)
module dist_topk_select #(
  parameter int VARWIDTH = 32,
  parameter int K        = 4,
  parameter int IDXWIDTH = 10
) (
  input  logic                clk,
  input  logic                RST_N,
  dist_topk_select_if.slave   bus
);
  localparam int CW = $clog2(K + 1);
  localparam logic [IDXWIDTH-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [VARWIDTH-1:0] dist_q [K];
  logic [VARWIDTH-1:0] dist_d [K];
  logic [IDXWIDTH-1:0] idx_q  [K];
  logic [IDXWIDTH-1:0] idx_d  [K];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDXWIDTH-1:0] nidx_q, nidx_d;
  logic                wrapped_q, wrapped_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  state_t              state_q, state_d;

  logic                accept;
  logic                drop;
  // ahead[j]: slot j is occupied and its distance <= dist_in, so it stays in
  // front of the new sample (ties keep the older candidate first). Because the
  // list is sorted, ahead is a thermometer code and its popcount is the
  // insertion position. ahead_ext[j] is "slot j-1 stays ahead", with a virtual
  // always-ahead slot below slot 0.
  logic [K-1:0]        ahead;
  logic [K:0]          ahead_ext;

  always_comb begin
    // OVF can only be set once wrapped is set, so wrapped alone gates acceptance.
    accept = bus.DIST_VALID && !bus.CLR && !done_q && !wrapped_q;
    drop   = bus.DIST_VALID && !bus.CLR && !done_q &&  wrapped_q;

    for (int j = 0; j < K; j++) begin
      // Compare against occupancy, not value: an all-ones distance in an
      // occupied slot is real, an all-ones empty slot never stays ahead.
      ahead[j] = (CW'(j) < cnt_q) && (dist_q[j] <= bus.dist_in);
    end
    ahead_ext = {ahead, 1'b1};

    for (int j = 0; j < K; j++) begin
      dist_d[j] = dist_q[j];
      idx_d[j]  = idx_q[j];
    end
    cnt_d     = cnt_q;
    nidx_d    = nidx_q;
    wrapped_d = wrapped_q;
    done_d    = done_q;
    ovf_d     = ovf_q;

    if (bus.CLR) begin
      for (int j = 0; j < K; j++) begin
        dist_d[j] = '1;
        idx_d[j]  = '1;
      end
      cnt_d     = '0;
      nidx_d    = '0;
      wrapped_d = 1'b0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
    end else if (accept) begin
      // Slots behind the insertion point shift down by one; slot K-1 falls off.
      // If every slot stays ahead the list is unchanged (sample discarded).
      for (int j = 0; j < K; j++) begin
        if (!ahead[j]) begin
          if (ahead_ext[j]) begin
            dist_d[j] = bus.dist_in;
            idx_d[j]  = nidx_q;
          end else begin
            dist_d[j] = dist_q[j-1];
            idx_d[j]  = idx_q[j-1];
          end
        end
      end
      if (cnt_q != CW'(K)) cnt_d = cnt_q + 1'b1;
      nidx_d = nidx_q + 1'b1;
      if (nidx_q == IDX_MAX) wrapped_d = 1'b1;
      if (bus.LAST) done_d = 1'b1;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (bus.LAST) done_d = 1'b1;
    end

    if (done_d)                   state_d = S_DONE;
    else if (cnt_d == '0)         state_d = S_IDLE;
    else if (cnt_d == CW'(K))     state_d = S_FULL;
    else                          state_d = S_FILL;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int j = 0; j < K; j++) begin
        dist_q[j] <= '1;
        idx_q[j]  <= '1;
      end
      cnt_q     <= '0;
      nidx_q    <= '0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
    end else begin
      for (int j = 0; j < K; j++) begin
        dist_q[j] <= dist_d[j];
        idx_q[j]  <= idx_d[j];
      end
      cnt_q     <= cnt_d;
      nidx_q    <= nidx_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    for (int j = 0; j < K; j++) begin
      bus.topk_dist[j*VARWIDTH +: VARWIDTH] = dist_q[j];
      bus.topk_idx[j*IDXWIDTH +: IDXWIDTH]  = idx_q[j];
    end
  end

  assign bus.topk_cnt  = cnt_q;
  assign bus.DONE      = done_q;
  assign bus.OVF       = ovf_q;
  assign bus.fsm_state = state_q;
endmodule
